// File: rtl/el2_exu_mul_sender.sv
// -----------------------------------------------------------------------------
// el2_exu_mul_sender
//
// Takes multiply results from the EXU multiplier pipeline and sends them into
// the NoC. Results enter through a valid/ready port and wait in a small FIFO.
// The result at the FIFO head is split into FLIT_BITS-wide flits, least
// significant flit first. The flits go out on a valid/ready/last injection
// port. All logic runs on clk_noc.
//
// Parameters
//   PACKET_BITS  payload width of one result
//   FLIT_BITS    NoC flit width; NFLITS = ceil(PACKET_BITS / FLIT_BITS)
//   FIFO_DEPTH   result buffer entries, 2 or 4 (must be a power of two)
//
// Ports
//   clk_noc       NoC clock, rising edge
//   rst           asynchronous active-high reset
//   noc_sr_flush  synchronous flush of the FIFO and of any packet in flight
//   in_valid      result valid from the multiplier
//   in_data       result value
//   in_ready      FIFO can take a result this cycle (= not full)
//   up_valid      flit valid toward the NoC
//   up_data       flit payload, zero-padded above PACKET_BITS
//   up_last       final flit of the current packet
//   up_ready      NoC accepts the flit
//   busy          FIFO holds at least one result
// -----------------------------------------------------------------------------
module el2_exu_mul_sender #(
  parameter int PACKET_BITS = 32,
  parameter int FLIT_BITS   = 8,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk_noc,
  input  logic                   rst,
  input  logic                   noc_sr_flush,
  input  logic                   in_valid,
  input  logic [PACKET_BITS-1:0] in_data,
  output logic                   in_ready,
  output logic                   up_valid,
  output logic [FLIT_BITS-1:0]   up_data,
  output logic                   up_last,
  input  logic                   up_ready,
  output logic                   busy
);

  localparam int NFLITS = (PACKET_BITS + FLIT_BITS - 1) / FLIT_BITS;
  localparam int IDX_W  = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PAD_W  = NFLITS * FLIT_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PACKET_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]       rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]       count, count_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  state_t                 state, state_nxt;

  logic                   push;
  logic                   flit_hs;
  logic                   last_flit;
  logic                   pop;
  logic [PAD_W-1:0]       head_pad;

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  // in_ready is only !full. It does not try to predict a pop in the same
  // cycle, so a full FIFO refuses input even when its last flit is leaving.
  assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign busy      = (count != '0);
  assign up_valid  = (state == SEND);

  // A flush drops any push or flit handshake that happens in the same cycle.
  assign push      = in_valid && in_ready && !noc_sr_flush;
  assign flit_hs   = up_valid && up_ready && !noc_sr_flush;
  assign last_flit = (idx == IDX_W'(NFLITS - 1));
  assign pop       = flit_hs && last_flit;

  // ---------------------------------------------------------------------------
  // Flit mux: zero-extend the head, then pick flit idx. When idle the output
  // is forced to zero, so stale storage never shows on the port (storage is
  // not reset).
  // ---------------------------------------------------------------------------
  assign head_pad = PAD_W'(mem[rd_ptr]);
  assign up_data  = up_valid ? head_pad[idx*FLIT_BITS +: FLIT_BITS] : '0;
  assign up_last  = up_valid && last_flit;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping and flit index
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    idx_nxt    = idx;

    if (noc_sr_flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
      idx_nxt    = '0;
    end else begin
      // FIFO_DEPTH is a power of two, so the pointers wrap by themselves.
      if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);

      // A push and a pop in the same cycle leave the count unchanged.
      unique case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase

      if (flit_hs) idx_nxt = last_flit ? '0 : idx + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM: next-state logic
  // ---------------------------------------------------------------------------
  // When another entry is queued, the last-flit pop keeps the FSM in SEND.
  // The next packet's flit 0 then shows in the following cycle with no bubble.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (count_nxt != '0)          state_nxt = SEND;
      SEND: if (pop && count_nxt == '0)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
    if (noc_sr_flush) state_nxt = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      idx    <= idx_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Result storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Only entries between rd_ptr and
  // wr_ptr are ever read, and the pointers and count are reset. Leaving the
  // array without reset allows it to map onto plain flops or RAM.
  always_ff @(posedge clk_noc) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_el2_exu_mul_sender.sv
module tb_el2_exu_mul_sender;

  localparam int FB    = 8;
  localparam int NF    = 4;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;

  // Default-parameter instance (8-bit flits)
  logic        a_flush, a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic        a_up_valid, a_up_last, a_up_ready, a_busy;
  logic [7:0]  a_up_data;

  // Padding instance (12-bit flits)
  logic        b_flush, b_in_valid, b_in_ready;
  logic [31:0] b_in_data;
  logic        b_up_valid, b_up_last, b_up_ready, b_busy;
  logic [11:0] b_up_data;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  // Reference model: a queue of whole results and the flit position in the head.
  int unsigned q[$];
  int          pos = 0;

  el2_exu_mul_sender #(.PACKET_BITS(32), .FLIT_BITS(8), .FIFO_DEPTH(2)) dut_a (
    .clk_noc      (clk),
    .rst          (rst),
    .noc_sr_flush (a_flush),
    .in_valid     (a_in_valid),
    .in_data      (a_in_data),
    .in_ready     (a_in_ready),
    .up_valid     (a_up_valid),
    .up_data      (a_up_data),
    .up_last      (a_up_last),
    .up_ready     (a_up_ready),
    .busy         (a_busy)
  );

  el2_exu_mul_sender #(.PACKET_BITS(32), .FLIT_BITS(12), .FIFO_DEPTH(2)) dut_b (
    .clk_noc      (clk),
    .rst          (rst),
    .noc_sr_flush (b_flush),
    .in_valid     (b_in_valid),
    .in_data      (b_in_data),
    .in_ready     (b_in_ready),
    .up_valid     (b_up_valid),
    .up_data      (b_up_data),
    .up_last      (b_up_last),
    .up_ready     (b_up_ready),
    .busy         (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every port of dut_a against what the model queue implies.
  task automatic check_model();
    logic        ev, el, er;
    logic [31:0] ed;
    ev = (q.size() != 0);
    ed = ev ? ((q[0] >> (pos * FB)) & 32'hFF) : 32'h0;
    el = ev && (pos == NF - 1);
    er = (q.size() < DEPTH);
    check($sformatf("up_valid@%0d", cyc), {31'b0, a_up_valid}, {31'b0, ev});
    check($sformatf("up_data@%0d", cyc),  {24'b0, a_up_data},  ed);
    check($sformatf("up_last@%0d", cyc),  {31'b0, a_up_last},  {31'b0, el});
    check($sformatf("in_ready@%0d", cyc), {31'b0, a_in_ready}, {31'b0, er});
    check($sformatf("busy@%0d", cyc),     {31'b0, a_busy},     {31'b0, ev});
  endtask

  // Advance the model by one clock edge using that edge's inputs.
  task automatic model_step(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic hs, pu;
    if (f) begin
      q.delete();
      pos = 0;
    end else begin
      hs = (q.size() != 0) && r;
      pu = v && (q.size() < DEPTH);
      if (hs) begin
        if (pos == NF - 1) begin
          void'(q.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (pu) q.push_back(d);
    end
  endtask

  // One clock cycle on dut_a: drive and check at the falling edge, then
  // update the model at the rising edge. The task returns just after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(negedge clk);
    a_in_valid = v;
    a_in_data  = d;
    a_up_ready = r;
    a_flush    = f;
    check_model();
    @(posedge clk);
    model_step(v, d, r, f);
    cyc++;
  endtask

  // Explicit constant checks 1 time unit after the edge that cycle() ended on.
  task automatic expect_a(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic b);
    #1;
    check({tag, ".valid"}, {31'b0, a_up_valid}, {31'b0, v});
    check({tag, ".data"},  {24'b0, a_up_data},  {24'b0, d});
    check({tag, ".last"},  {31'b0, a_up_last},  {31'b0, l});
    check({tag, ".busy"},  {31'b0, a_busy},     {31'b0, b});
  endtask

  initial begin
    rst        = 1'b1;
    a_flush    = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_up_ready = 1'b0;
    b_flush    = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_up_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.up_valid", {31'b0, a_up_valid}, 32'd0);
    check("rst.up_last",  {31'b0, a_up_last},  32'd0);
    check("rst.up_data",  {24'b0, a_up_data},  32'd0);
    check("rst.busy",     {31'b0, a_busy},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst.in_ready", {31'b0, a_in_ready}, 32'd1);

    // Width padding on the 12-bit instance; dut_a stays idle and empty.
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 32'h1234_5678; b_up_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    check("pad.f0.valid", {31'b0, b_up_valid}, 32'd1);
    check("pad.f0.data",  {20'b0, b_up_data},  32'h678);
    check("pad.f0.last",  {31'b0, b_up_last},  32'd0);
    @(negedge clk);
    check("pad.f1.data",  {20'b0, b_up_data},  32'h345);
    check("pad.f1.last",  {31'b0, b_up_last},  32'd0);
    @(negedge clk);
    check("pad.f2.data",  {20'b0, b_up_data},  32'h012);
    check("pad.f2.last",  {31'b0, b_up_last},  32'd1);
    @(negedge clk);
    check("pad.end.valid", {31'b0, b_up_valid}, 32'd0);
    check("pad.end.busy",  {31'b0, b_busy},     32'd0);

    // Single packet
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0); expect_a("single.f0", 1, 8'hEF, 0, 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);         expect_a("single.f1", 1, 8'hBE, 0, 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);         expect_a("single.f2", 1, 8'hAD, 0, 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);         expect_a("single.f3", 1, 8'hDE, 1, 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);         expect_a("single.end", 0, 8'h00, 0, 0);

    // Backpressure until full, then release
    cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    #1 check("full.in_ready", {31'b0, a_in_ready}, 32'd0);
    cycle(1'b1, 32'h3333_3333, 1'b0, 1'b0); expect_a("stall.a", 1, 8'h11, 0, 1);
    cycle(1'b1, 32'h3333_3333, 1'b0, 1'b0); expect_a("stall.b", 1, 8'h11, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      if (i == 3) begin
        expect_a("release.pkt2", 1, 8'h22, 0, 1);
        check("release.in_ready", {31'b0, a_in_ready}, 32'd1);
      end
    end
    expect_a("release.end", 0, 8'h00, 0, 0);

    // Flush mid-packet with a concurrent push
    cycle(1'b1, 32'hAABB_CCDD, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);         expect_a("preflush", 1, 8'hBB, 0, 1);
    cycle(1'b1, 32'h0102_0304, 1'b1, 1'b1); expect_a("flush", 0, 8'h00, 0, 0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);         expect_a("flush.quiet", 0, 8'h00, 0, 0);
    cycle(1'b1, 32'h0506_0708, 1'b1, 1'b0); expect_a("postflush", 1, 8'h08, 0, 1);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while flit 2 is on the port
    cycle(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);         expect_a("prerst", 1, 8'hFE, 0, 1);
    #1 rst = 1'b1;
    #1;
    check("arst.up_valid", {31'b0, a_up_valid}, 32'd0);
    check("arst.up_last",  {31'b0, a_up_last},  32'd0);
    check("arst.up_data",  {24'b0, a_up_data},  32'd0);
    check("arst.busy",     {31'b0, a_busy},     32'd0);
    a_in_valid = 1'b0; a_flush = 1'b0;
    q.delete();
    pos = 0;
    @(negedge clk);
    rst = 1'b0;
    check("arst.in_ready", {31'b0, a_in_ready}, 32'd1);
    cycle(1'b1, 32'h0BAD_C0DE, 1'b1, 1'b0); expect_a("postrst", 1, 8'hDE, 0, 1);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Push on the same cycle the only entry's last flit handshakes
    cycle(1'b1, 32'hA1A2_A3A4, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'hB1B2_B3B4, 1'b1, 1'b0); expect_a("pushpop", 1, 8'hB4, 0, 1);
    check("pushpop.in_ready", {31'b0, a_in_ready}, 32'd1);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0));
    end
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
